// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter that serialises per-core line reads and writebacks onto one memory port.
// Define MEM_ARB_TIMEOUT_EN to enable a watchdog that ends a stuck BUSY with an error response.
module mem_bus_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int ADDR_W         = 32,
  parameter int LINE_W         = 128,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] req_we,
  input  logic [ADDR_W-1:0]  req_addr  [NUM_REQ],
  input  logic [LINE_W-1:0]  req_wdata [NUM_REQ],
  output logic [NUM_REQ-1:0] grant,
  output logic [NUM_REQ-1:0] resp_valid,
  output logic [NUM_REQ-1:0] resp_err,
  output logic [LINE_W-1:0]  resp_data,
  output logic [NUM_REQ-1:0] stall,
  output logic               mem_req,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [LINE_W-1:0]  mem_wdata,
  input  logic [LINE_W-1:0]  mem_read_data,
  input  logic               mem_ready
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("mem_bus_arbiter: TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;

  state_t             state, state_nxt;
  logic [PTR_W-1:0]   rr_ptr, rr_ptr_nxt;
  logic [PTR_W-1:0]   owner, owner_nxt;
  logic [PTR_W-1:0]   winner, cand;
  logic [NUM_REQ-1:0] grant_nxt, resp_valid_nxt, resp_err_nxt;
  logic [LINE_W-1:0]  resp_data_nxt;
  logic               mem_req_nxt, mem_we_nxt;
  logic [ADDR_W-1:0]  mem_addr_nxt;
  logic [LINE_W-1:0]  mem_wdata_nxt;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt, cnt_nxt;
`endif

  assign stall = req & ~resp_valid;

  // Descending scan so the candidate closest to rr_ptr is the last one written and wins.
  always_comb begin
    winner = rr_ptr;
    cand   = rr_ptr;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = PTR_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (req[cand]) winner = cand;
    end
  end

  always_comb begin
    // NOTE: every output of this block is given a hold value first so no path infers a latch.
    state_nxt      = state;
    rr_ptr_nxt     = rr_ptr;
    owner_nxt      = owner;
    grant_nxt      = grant;
    resp_valid_nxt = resp_valid;
    resp_err_nxt   = resp_err;
    resp_data_nxt  = resp_data;
    mem_req_nxt    = mem_req;
    mem_we_nxt     = mem_we;
    mem_addr_nxt   = mem_addr;
    mem_wdata_nxt  = mem_wdata;
`ifdef MEM_ARB_TIMEOUT_EN
    cnt_nxt        = cnt;
`endif
    case (state)
      S_IDLE: begin
        if (|req) begin
          owner_nxt     = winner;
          grant_nxt     = NUM_REQ'(1) << winner;
          mem_req_nxt   = 1'b1;
          mem_we_nxt    = req_we[winner];
          mem_addr_nxt  = req_addr[winner];
          mem_wdata_nxt = req_wdata[winner];
`ifdef MEM_ARB_TIMEOUT_EN
          cnt_nxt       = '0;
`endif
          state_nxt     = S_BUSY;
        end
      end
      S_BUSY: begin
        if (mem_ready) begin
          mem_req_nxt    = 1'b0;
          resp_valid_nxt = NUM_REQ'(1) << owner;
          if (!mem_we) resp_data_nxt = mem_read_data;
          state_nxt      = S_RESP;
        end
`ifdef MEM_ARB_TIMEOUT_EN
        else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          mem_req_nxt    = 1'b0;
          resp_valid_nxt = NUM_REQ'(1) << owner;
          resp_err_nxt   = NUM_REQ'(1) << owner;
          resp_data_nxt  = '0;
          state_nxt      = S_RESP;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
`endif
      end
      S_RESP: begin
        resp_valid_nxt = '0;
        resp_err_nxt   = '0;
        grant_nxt      = '0;
        rr_ptr_nxt     = (owner == PTR_W'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
        state_nxt      = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      rr_ptr     <= '0;
      owner      <= '0;
      grant      <= '0;
      resp_valid <= '0;
      resp_err   <= '0;
      resp_data  <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
      cnt        <= '0;
`endif
    end else begin
      state      <= state_nxt;
      rr_ptr     <= rr_ptr_nxt;
      owner      <= owner_nxt;
      grant      <= grant_nxt;
      resp_valid <= resp_valid_nxt;
      resp_err   <= resp_err_nxt;
      resp_data  <= resp_data_nxt;
      mem_req    <= mem_req_nxt;
      mem_we     <= mem_we_nxt;
      mem_addr   <= mem_addr_nxt;
      mem_wdata  <= mem_wdata_nxt;
`ifdef MEM_ARB_TIMEOUT_EN
      cnt        <= cnt_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed scenarios followed by randomized traffic
// compared against a transaction-level round-robin model.
module tb_mem_bus_arbiter;
  localparam int N  = 4;
  localparam int AW = 32;
  localparam int LW = 128;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req, req_we;
  logic [AW-1:0] req_addr  [N];
  logic [LW-1:0] req_wdata [N];
  logic [N-1:0]  grant, resp_valid, resp_err, stall;
  logic [LW-1:0] resp_data, mem_wdata, mem_read_data;
  logic          mem_req, mem_we, mem_ready;
  logic [AW-1:0] mem_addr;

  int checks = 0;
  int errors = 0;

  // Reference model state: round-robin start point and last line returned to any core.
  int            m_ptr;
  logic [LW-1:0] m_data;

  mem_bus_arbiter #(
    .NUM_REQ(N), .ADDR_W(AW), .LINE_W(LW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .req(req), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .grant(grant), .resp_valid(resp_valid), .resp_err(resp_err), .resp_data(resp_data),
    .stall(stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_read_data(mem_read_data), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [LW-1:0] rand_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic int pick(input logic [N-1:0] r, input int ptr);
    for (int k = 0; k < N; k++) if (r[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  task automatic set_req(input int c, input logic we, input logic [AW-1:0] a,
                         input logic [LW-1:0] d);
    req[c]       = 1'b1;
    req_we[c]    = we;
    req_addr[c]  = a;
    req_wdata[c] = d;
  endtask

  task automatic add_random_reqs();
    for (int j = 0; j < N; j++)
      if (!req[j] && $urandom_range(0, 3) == 0)
        set_req(j, 1'($urandom_range(0, 1)), $urandom, rand_line());
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    m_ptr  = 0;
    m_data = '0;
  endtask

  // One complete transaction from IDLE: grant, `delay` stalled BUSY cycles, response, RESP.
  task automatic do_txn(input int delay, input logic [LW-1:0] rd, input bit hold,
                        input bit grow, output int w);
    logic [N-1:0]  oh;
    logic          we;
    logic [AW-1:0] a;
    logic [LW-1:0] d;
    w = pick(req, m_ptr);
    if (w < 0) begin
      check("txn_has_request", {{(LW-N){1'b0}}, req}, 1);
      return;
    end
    oh = N'(1) << w;
    we = req_we[w];
    a  = req_addr[w];
    d  = req_wdata[w];
    mem_ready = (delay == 0);
    tick();
    check("grant", grant, oh);
    check("mem_req_on", mem_req, 1);
    check("mem_we", mem_we, we);
    check("mem_addr", mem_addr, a);
    if (we) check("mem_wdata", mem_wdata, d);
    check("no_early_resp", resp_valid, 0);
    for (int i = 0; i < delay; i++) begin
      if (grow) add_random_reqs();
      tick();
      check("busy_mem_req", mem_req, 1);
      check("busy_addr_stable", mem_addr, a);
      check("busy_no_resp", resp_valid, 0);
      check("busy_stall", stall, req);
    end
    mem_ready     = 1'b1;
    mem_read_data = rd;
    tick();
    if (!we) m_data = rd;
    check("resp_valid", resp_valid, oh);
    check("resp_err_clear", resp_err, 0);
    check("resp_data", resp_data, m_data);
    check("mem_req_off", mem_req, 0);
    check("resp_stall", stall, req & ~oh);
    if (!hold) mem_ready = 1'b0;
    req[w] = 1'b0;
    tick();
    check("resp_pulse_ends", resp_valid, 0);
    check("grant_released", grant, 0);
    m_ptr = (w + 1) % N;
  endtask

  initial begin
    int w;
    logic [N-1:0] oh;
    rst           = 1'b1;
    req           = '0;
    req_we        = '0;
    mem_ready     = 1'b0;
    mem_read_data = '0;
    for (int i = 0; i < N; i++) begin
      req_addr[i]  = '0;
      req_wdata[i] = '0;
    end

    // Reset state
    do_reset();
    check("rst_grant", grant, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_err", resp_err, 0);
    check("rst_resp_data", resp_data, 0);
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_stall", stall, 0);

    // Single read from core 0 with memory immediately ready
    set_req(0, 1'b0, 32'h1111_1000, '0);
    do_txn(0, 128'h1234_5678_9ABC_DEF0_1234_5678_9ABC_DEF0, 1'b0, 1'b0, w);

    // Writeback from core 2 leaves resp_data at the previous read line
    set_req(2, 1'b1, 32'h1000_0000, 128'hDEAD_BEEF_CAFE_F00D_0123_4567_89AB_CDEF);
    do_txn(2, rand_line(), 1'b0, 1'b0, w);

    // All four cores continuously requesting with mem_ready held high: strict rotation
    do_reset();
    for (int c = 0; c < N; c++) set_req(c, 1'b0, 32'h2000_0000 + 32'(c * 64), '0);
    for (int i = 0; i < N + 1; i++) begin
      do_txn(0, rand_line(), 1'b1, 1'b0, w);
      check("rotation_order", w, i % N);
      req[w] = 1'b1;
    end
    mem_ready = 1'b0;

    // Slow memory: ten stalled BUSY cycles with every other core waiting
    do_txn(10, rand_line(), 1'b0, 1'b0, w);
    for (int c = 0; c < N; c++) req[c] = 1'b0;

    // Reset in the middle of a transaction, then rotation restarts from core 0
    for (int c = 0; c < N; c++) set_req(c, 1'b0, 32'h3000_0000 + 32'(c), '0);
    tick();
    check("pre_reset_busy", mem_req, 1);
    req = '0;
    do_reset();
    check("midrst_grant", grant, 0);
    check("midrst_mem_req", mem_req, 0);
    check("midrst_mem_addr", mem_addr, 0);
    check("midrst_resp_valid", resp_valid, 0);
    set_req(1, 1'b0, 32'h4000_0010, '0);
    set_req(3, 1'b1, 32'h4000_0030, rand_line());
    do_txn(0, rand_line(), 1'b0, 1'b0, w);
    check("post_reset_first", w, 1);
    do_txn(1, rand_line(), 1'b0, 1'b0, w);

    // Randomized traffic against the round-robin model
    for (int t = 0; t < 60; t++) begin
      add_random_reqs();
      if (req == '0) set_req($urandom_range(0, N - 1), 1'($urandom_range(0, 1)), $urandom,
                             rand_line());
      do_txn($urandom_range(0, 5), rand_line(), 1'b0, 1'b1, w);
    end
    req = '0;

    // Memory never answers: watchdog response if enabled, otherwise an indefinite wait
    set_req(2, 1'b0, 32'h5000_0000, '0);
    w  = pick(req, m_ptr);
    oh = N'(1) << w;
    mem_ready = 1'b0;
    tick();
    check("stuck_grant", grant, oh);
`ifdef MEM_ARB_TIMEOUT_EN
    for (int i = 1; i < TO; i++) begin
      tick();
      check("timeout_wait", resp_valid, 0);
    end
    tick();
    check("timeout_resp_valid", resp_valid, oh);
    check("timeout_resp_err", resp_err, oh);
    check("timeout_resp_data", resp_data, 0);
    check("timeout_mem_req", mem_req, 0);
    m_data = '0;
    req[w] = 1'b0;
    tick();
    check("timeout_err_clear", resp_err, 0);
`else
    for (int i = 0; i < 3 * TO; i++) begin
      tick();
      check("no_timeout_resp", resp_valid, 0);
      check("no_timeout_err", resp_err, 0);
      check("no_timeout_mem_req", mem_req, 1);
    end
    mem_ready     = 1'b1;
    mem_read_data = rand_line();
    m_data        = mem_read_data;
    tick();
    check("late_resp_valid", resp_valid, oh);
    check("late_resp_data", resp_data, m_data);
    mem_ready = 1'b0;
    req[w]    = 1'b0;
    tick();
`endif
    check("final_grant", grant, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Run-time guard: the directed sequence is far shorter than this.
  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "bench watchdog expired");
  end

endmodule
